// File: rtl/riscv_pkg.sv
// Shared core definitions: hazard controller state encoding and the x0 register index.
package riscv_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hazard_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count up on inc, holding at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use stalls, taken-branch
// flushes and data-memory wait freezing with a timeout watchdog.
// Define HAZARD_PERF_EN to build the stall/flush performance counters; otherwise both
// counter outputs are tied to zero.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TO_W        = 8,
  parameter int unsigned MEM_TIMEOUT = 200,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // Counter value seen in the last allowed wait cycle; the entry cycle counts as 1.
  localparam logic [TO_W-1:0] TimeoutLast = TO_W'(MEM_TIMEOUT - 1);

  hazard_state_t   state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            mem_err_q, mem_err_d;
  logic            lu;
  logic            run_rules;

  assign lu = idex_memread && (idex_rd != REG_ZERO) &&
              ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  // Next-state and zero-latency control outputs.
  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    mem_err_d    = mem_err_q;
    run_rules    = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;

    unique case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_d  = MEM_WAIT;
          to_cnt_d = TO_W'(1);
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        // A dropped request is treated as completion.
        if (dmem_ready || !dmem_req) begin
          state_d   = RUN;
          to_cnt_d  = '0;
          run_rules = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_q >= TimeoutLast) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
          end
        end
      end
      ERR: begin
        run_rules = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (!run_rules) begin
      // Freeze: hold every stage and keep garbage out of writeback.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (branch_taken) begin
      // Branch wins over load-use: the stalled instruction is discarded anyway.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end

    if (reset) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end
  end

  // State, watchdog counter and sticky error register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      to_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = !reset && !pc_en;
  assign flush_inc = !reset && ifid_flush;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall_inc),
    .count(stall_cycles)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (flush_inc),
    .count(flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (small timeout and 4-bit counters).
module tb_hazard_ctrl;

  localparam int unsigned TO_W        = 8;
  localparam int unsigned MEM_TIMEOUT = 10;
  localparam int unsigned CNT_W       = 4;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble}
  localparam logic [6:0] C_NORM   = 7'b1101010;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_LU     = 7'b0001110;
  localparam logic [6:0] C_RST    = 7'b0010101;

  logic             clk = 1'b0;
  logic             reset;
  logic             idex_memread;
  logic [4:0]       idex_rd;
  logic [4:0]       ifid_rs1;
  logic [4:0]       ifid_rs2;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .TO_W       (TO_W),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .idex_memread(idex_memread),
    .idex_rd     (idex_rd),
    .ifid_rs1    (ifid_rs1),
    .ifid_rs2    (ifid_rs2),
    .branch_taken(branch_taken),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_en     (idex_en),
    .idex_flush  (idex_flush),
    .exmem_en    (exmem_en),
    .memwb_bubble(memwb_bubble),
    .mem_err     (mem_err),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
  );

  function automatic logic [6:0] ctrl();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Let combinational outputs settle after new inputs, away from the clock edge.
  task automatic settle();
    #2;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int stall_exp, input int flush_exp);
    chk({tag, "_stall"}, 32'(stall_cycles), PERF ? 32'(stall_exp) : 32'd0);
    chk({tag, "_flush"}, 32'(flush_count), PERF ? 32'(flush_exp) : 32'd0);
  endtask

  initial begin
    reset = 1'b1; idex_memread = 1'b0; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
    branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    #1; settle();
    chk("rst_ctrl_async_view", 32'(ctrl()), 32'(C_RST));
    tick(); settle();
    chk("rst_ctrl", 32'(ctrl()), 32'(C_RST));
    reset = 1'b0; settle();
    chk("run_idle", 32'(ctrl()), 32'(C_NORM));
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk_cnt("rst_cnt", 0, 0);

    // Load-use via rs2: one-cycle stall.
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; settle();
    chk("lu_rs2", 32'(ctrl()), 32'(C_LU));
    tick(); idex_memread = 1'b0; settle();
    chk("lu_released", 32'(ctrl()), 32'(C_NORM));
    chk_cnt("lu_cnt", 1, 0);

    // Load into x0 never stalls.
    idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; settle();
    chk("lu_x0", 32'(ctrl()), 32'(C_NORM));
    tick();

    // Branch together with load-use: branch wins.
    idex_rd = 5'd7; ifid_rs1 = 5'd7; branch_taken = 1'b1; settle();
    chk("branch_over_lu", 32'(ctrl()), 32'(C_BRANCH));
    tick(); branch_taken = 1'b0; settle();
    chk_cnt("branch_cnt", 1, 1);
    chk("lu_rs1", 32'(ctrl()), 32'(C_LU));
    tick(); idex_memread = 1'b0; settle();
    chk_cnt("lu_rs1_cnt", 2, 1);

    reset = 1'b1; tick(); reset = 1'b0; settle();
    chk_cnt("clr_cnt", 0, 0);

    // Memory wait: 3 frozen cycles, completion on the 4th.
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("mwait_%0d", i), 32'(ctrl()), 32'(C_FREEZE));
      tick();
    end
    dmem_ready = 1'b1; settle();
    chk("mwait_done", 32'(ctrl()), 32'(C_NORM));
    chk_cnt("mwait_cnt", 3, 0);
    tick(); dmem_req = 1'b0; dmem_ready = 1'b0; settle();
    chk("mwait_back_run", 32'(ctrl()), 32'(C_NORM));

    // Completion cycle carrying a taken branch.
    dmem_req = 1'b1; tick(); dmem_ready = 1'b1; branch_taken = 1'b1; settle();
    chk("mwait_done_branch", 32'(ctrl()), 32'(C_BRANCH));
    tick(); branch_taken = 1'b0; dmem_ready = 1'b0; dmem_req = 1'b0; settle();
    chk_cnt("mwait_branch_cnt", 4, 1);

    // Dropped request ends the wait.
    dmem_req = 1'b1; tick(); dmem_req = 1'b0; settle();
    chk("mwait_req_drop", 32'(ctrl()), 32'(C_NORM));
    tick(); settle();
    chk_cnt("req_drop_cnt", 5, 1);

    // Reset after two wait cycles abandons the access.
    dmem_req = 1'b1; tick(); tick(); reset = 1'b1; dmem_req = 1'b0; settle();
    chk("midwait_rst_ctrl", 32'(ctrl()), 32'(C_RST));
    tick(); reset = 1'b0; settle();
    chk("midwait_after", 32'(ctrl()), 32'(C_NORM));
    chk_cnt("midwait_cnt", 0, 0);

    // Timeout: MEM_TIMEOUT frozen cycles, then sticky error; stall counter saturates.
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < int'(MEM_TIMEOUT); i++) begin
      settle();
      chk($sformatf("to_wait_%0d", i), 32'(ctrl()), 32'(C_FREEZE));
      chk($sformatf("to_err_low_%0d", i), 32'(mem_err), 32'd0);
      tick();
    end
    settle();
    chk("to_err_set", 32'(mem_err), 32'd1);
    chk("to_err_ctrl", 32'(ctrl()), 32'(C_FREEZE));
    chk_cnt("to_cnt", 10, 0);
    dmem_req = 1'b0; branch_taken = 1'b1; settle();
    chk("err_ignores_branch", 32'(ctrl()), 32'(C_FREEZE));
    for (int i = 0; i < 10; i++) tick();
    branch_taken = 1'b0; settle();
    chk("err_sticky", 32'(mem_err), 32'd1);
    chk_cnt("sat_cnt", 15, 0);
    reset = 1'b1; tick(); reset = 1'b0; settle();
    chk("err_cleared", 32'(mem_err), 32'd0);
    chk("err_back_run", 32'(ctrl()), 32'(C_NORM));
    chk_cnt("err_rst_cnt", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV core.
- Drives the enable/flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three hazard sources:
  - load-use data hazards
  - taken-branch control hazards
  - multi-cycle data-memory waits, via a small FSM with a timeout watchdog.
- Sits beside the datapath; all pipeline registers take their enables and flushes from this block.

Parameters:
- TO_W, 8, width of the memory-wait timeout counter.
- MEM_TIMEOUT, 200, wait cycles allowed before declaring a memory error (must be < 2^TO_W).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- idex_memread  in  1  instruction in EX is a load.
- idex_rd  in  5  destination register of the instruction in EX.
- ifid_rs1  in  5  rs1 of the instruction in ID.
- ifid_rs2  in  5  rs2 of the instruction in ID.
- branch_taken  in  1  branch/jump resolved taken in EX.
- dmem_req  in  1  instruction in MEM accesses data memory this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clear (synchronous, with reset-style zeroing).
- idex_en  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX clear (bubble).
- exmem_en  out  1  EX/MEM load enable.
- memwb_bubble  out  1  force memtoreg_in/regwrite_in of MEM/WB to 0.
- mem_err  out  1  sticky memory timeout error.
- stall_cycles  out  CNT_W  perf: cycles with pc_en=0.
- flush_count  out  CNT_W  perf: taken-branch flushes.

Behaviour:
- State (registered): RUN, MEM_WAIT, ERR. Reset -> RUN, timeout counter 0, mem_err 0, both perf counters 0.
- Control outputs are combinational from the current state and inputs, i.e. zero latency. While reset=1: all enables 0, ifid_flush=idex_flush=1, memwb_bubble=1.
- Load-use condition, lu = idex_memread & (idex_rd!=0) & (idex_rd==ifid_rs1 | idex_rd==ifid_rs2).
- RUN, priority order:
  - dmem_req & !dmem_ready: freeze all (pc_en=ifid_en=idex_en=exmem_en=0), memwb_bubble=1, no flushes; next state MEM_WAIT, timeout counter <= 1.
  - else branch_taken: all enables 1, ifid_flush=1, idex_flush=1. Branch overrides lu; the stalled instruction is discarded anyway.
  - else lu: pc_en=0, ifid_en=0, idex_flush=1, others enabled. This gives a single-cycle stall.
  - else: all enables 1, flushes 0, memwb_bubble 0.
- MEM_WAIT:
  - While waiting, outputs are the same freeze as the entry cycle; the counter increments each cycle.
  - On dmem_ready=1: enables 1, memwb_bubble 0, -> RUN. A branch_taken or lu present in that same cycle is applied as in RUN (same priority).
  - If the counter reaches MEM_TIMEOUT without dmem_ready: -> ERR, mem_err <= 1.
- ERR: all enables 0, memwb_bubble=1, flushes 0. Stays until reset; mem_err stays 1 until reset.
- dmem_req deasserting during MEM_WAIT is treated as completion (same as dmem_ready).
- Counters:
  - stall_cycles increments on every non-reset cycle with pc_en=0.
  - flush_count increments on every cycle with branch_taken applied (ifid_flush=1 outside reset).
  - Both saturate at all-ones.
- Reset mid-MEM_WAIT: next cycle is RUN with the counter cleared; the in-flight access is abandoned.

Optional Feature:
- HAZARD_PERF_EN defined: stall_cycles and flush_count are implemented as above.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package (riscv_pkg): the hazard_state_t enum (RUN, MEM_WAIT, ERR) and the REG_ZERO=5'd0 constant.
- One natural sub-module, sat_counter (width parameter, inc, reset), instantiated twice under HAZARD_PERF_EN.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5, ifid_rs2=5 -> pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle; with idex_rd=0 -> no stall.
- Branch: branch_taken=1 together with lu=1 -> ifid_flush=idex_flush=1, pc_en=1, flush_count +1.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> enables 0 and memwb_bubble=1 for 3 cycles, RUN on the 4th, stall_cycles=3.
- Timeout: dmem_req=1, dmem_ready never -> mem_err=1 after MEM_TIMEOUT cycles, enables stay 0; reset -> mem_err=0, state RUN.
- Reset mid-wait: reset after 2 wait cycles -> next cycle pc_en=1 (no req), counters 0.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cycles=15.
